tick_gen_multi: RTL and testbench
=================================

Name: tick_gen_multi

Overview:
- Parametrised multi-channel tick generator, successor to the fixed 250 Hz / 1 MHz divider.
- Derives NUM_CH independent strobes from clk_100M.
- Each channel has a runtime-programmable divisor with glitch-free reload at period boundaries, a per-channel enable, and an optional 50%-style square output.
- Feeds the piano's scan, debounce and tone-timing logic; a global sync realigns all channel phases.

Parameters:
- NUM_CH, 2, number of channels (1..16).
- DIV_W, 32, divisor/counter width.
- DIV_INIT, {32'd100, 32'd400000}, packed NUM_CH*DIV_W reset divisors, channel 0 in LSBs (ch0 = 250 Hz, ch1 = 1 MHz at 100 MHz).
- CH_W, $clog2(NUM_CH) min 1, cfg_ch width (derived, not overridden).

Ports:
- clk_100M  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  NUM_CH  per-channel run enable.
- mode_sq  in  NUM_CH  1 = drive sq[i]; 0 = sq[i] held 0.
- sync  in  1  synchronous phase restart, all channels.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  CH_W  channel select for write.
- cfg_div  in  DIV_W  new divisor N.
- tick  out  NUM_CH  one-cycle strobe every N cycles.
- sq  out  NUM_CH  square output.

Behaviour:
- Per channel state: shadow divisor div_sh, active divisor div_act, counter cnt (all DIV_W). Outputs are registered.
- Reset (async, rst_n low):
  - div_sh = div_act = DIV_INIT slice.
  - cnt = 0; tick = 0; sq = 0.
- Run (en[i]=1, div_act=N≥1, sync=0), each edge:
  - cnt <= (cnt==N-1) ? 0 : cnt+1.
  - tick[i] <= (cnt==N-1).
  - First tick is high in the Nth cycle after reset release or enable; thereafter exactly one high cycle per N cycles.
- N=1: tick[i] high every cycle.
- N=0: channel idle; cnt=0, tick=0, sq=0. div_act keeps reloading from div_sh each cycle, so writing a non-zero value starts the channel.
- Square output:
  - sq[i] <= mode_sq[i] & en[i] & (phase < N>>1), where phase is the post-edge cnt position measured from the tick cycle.
  - sq is high on the tick cycle plus the following floor(N/2)-1 cycles, then low for ceil(N/2) cycles.
  - N=1: sq constant 0.
  - Toggling mode_sq affects only sq, never tick or cnt.
- Divisor write:
  - cfg_we=1 with cfg_ch<NUM_CH: div_sh[cfg_ch] <= cfg_div on that edge.
  - cfg_ch≥NUM_CH: write ignored.
- Reload:
  - div_act <= div_sh on the wrap edge (cnt==N-1), when en[i]=0, when N=0, or on sync.
  - The running period is never truncated or stretched by a write.
- Write on the same edge as a wrap: reload takes the pre-write div_sh; the new value applies at the following boundary.
- en[i]=0: cnt <= 0, tick <= 0, sq <= 0, div_act tracks div_sh. Re-enable behaves exactly as post-reset.
- sync=1: all channels cnt <= 0, tick <= 0, sq <= 0, div_act <= div_sh. sync beats a simultaneous wrap (that tick is suppressed). After sync deasserts, enabled channels with equal N tick on the same cycle.
- Counter arithmetic: unsigned DIV_W. Counter never exceeds N-1; no overflow path.

Decomposition:
- Package clocks_pkg holds:
  - DIV_W default.
  - Named divisor constants DIV_250HZ=400000 and DIV_1MHZ=100.
  - Helper function clog2_min1.
- Sub-module tick_chan:
  - One channel: div_sh, div_act, cnt, tick, sq.
  - Ports: clk_100M, rst_n, en, mode_sq, sync, wr, wdata, init.
- Top level decodes cfg_ch into a per-channel wr and instantiates tick_chan NUM_CH times in a generate loop.

Test Plan:
- Reset with DIV_INIT={3,4}, en=11, mode_sq=00 -> tick[0] high cycles 4,8,12; tick[1] high cycles 3,6,9; sq=00 throughout.
- ch0 N=4, mode_sq[0]=1 -> sq[0] pattern 1,1,0,0 repeating, sq rising with each tick. Then write N=5 -> pattern 1,1,0,0,0 starting at the next boundary, not mid-period.
- ch0 N=4: cfg_we with cfg_div=2 issued 1 cycle before the wrap, then again exactly on the wrap edge -> early write: next period is 2. Wrap-edge write: one more period of 4, then 2.
- Run ch0 N=4, ch1 N=4 out of phase; assert sync 1 cycle coincident with a ch0 wrap -> no tick that cycle; afterwards both ticks coincide every 4 cycles.
- Write N=0 to ch1 -> tick[1]/sq[1] stay 0. Write N=1 -> tick[1] high every cycle from 2nd edge. Write with cfg_ch=3 (NUM_CH=2) -> no channel changes.
- Drop rst_n mid-period (cnt=2 of N=4) and drop en[0] mid-period, each as a separate run -> reset: outputs 0 immediately (async), divisors back to DIV_INIT. Enable drop: tick/sq 0 next edge; re-enable gives first tick 4 cycles later.

Source files
------------

// File: rtl/clocks_pkg.sv
// Shared clocking constants and helpers for the tick generator family.
// Divisors are expressed in clk_100M cycles.
package clocks_pkg;

    localparam int DIV_W_DEF = 32;

    localparam logic [31:0] DIV_250HZ = 32'd400000;
    localparam logic [31:0] DIV_1MHZ  = 32'd100;

    // Select-field width that stays at least one bit for single-channel builds
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((32'd1 << r) < n) begin
                r = r + 1;
            end else begin
                r = r;
            end
        end
        if (r == 0) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: shadow/active divisor, phase counter, tick strobe and square output.
// A new divisor is taken into the active register only at a period boundary, while idle, or on sync.
module tick_chan
    import clocks_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode_sq,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wdata,
    input  logic [DIV_W-1:0] init,
    output logic             tick,
    output logic             sq
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_div_sh;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_sq;

    logic             w_idle;
    logic             w_wrap;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_sq_nxt;

    // Next-state decode: idle covers disable, zero divisor and sync; sync also wins over a wrap
    always_comb begin
        w_idle    = 1'b0;
        w_wrap    = 1'b0;
        w_cnt_nxt = '0;
        w_sq_nxt  = 1'b0;
        w_idle    = sync | ~en | (r_div_act == '0);
        w_wrap    = ~w_idle & (r_cnt == (r_div_act - ONE));
        if (w_idle) begin
            w_cnt_nxt = '0;
        end else if (w_wrap) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + ONE;
        end
        w_sq_nxt  = ~w_idle & mode_sq & (w_cnt_nxt < (r_div_act >> 1));
    end

    // Shadow divisor: software-visible, written any time
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_div_sh <= init;
        end else if (wr) begin
            r_div_sh <= wdata;
        end else begin
            r_div_sh <= r_div_sh;
        end
    end

    // Counter, active divisor and registered outputs
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_div_act <= init;
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_sq      <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_tick    <= w_wrap;
            r_sq      <= w_sq_nxt;
            if (w_idle || w_wrap) begin
                r_div_act <= r_div_sh;
            end else begin
                r_div_act <= r_div_act;
            end
        end
    end

    assign tick = r_tick;
    assign sq   = r_sq;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: NUM_CH independent programmable strobes from clk_100M.
// cfg_ch values at or above NUM_CH select no channel, so such writes are dropped.
module tick_gen_multi
    import clocks_pkg::*;
#(
    parameter int                        NUM_CH   = 2,
    parameter int                        DIV_W    = DIV_W_DEF,
    parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT = {DIV_1MHZ, DIV_250HZ},
    localparam int                       CH_W     = clog2_min1(NUM_CH)
) (
    input  logic              clk_100M,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode_sq,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    logic [NUM_CH-1:0] w_wr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr[g] = cfg_we & (cfg_ch == CH_W'(g));

        tick_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk_100M (clk_100M),
            .rst_n    (rst_n),
            .en       (en[g]),
            .mode_sq  (mode_sq[g]),
            .sync     (sync),
            .wr       (w_wr[g]),
            .wdata    (cfg_div),
            .init     (DIV_INIT[g*DIV_W +: DIV_W]),
            .tick     (tick[g]),
            .sq       (sq[g])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi: a cycle-count reference model queues expected outputs,
// a monitor compares them one cycle later. Directed scenarios first, then random traffic.
module tb_tick_gen_multi;

    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam logic [NCH*DW-1:0] INIT = {32'd5, 32'd3, 32'd4};

    logic            clk_100M = 1'b0;
    logic            rst_n    = 1'b0;
    logic [NCH-1:0]  en       = '0;
    logic [NCH-1:0]  mode_sq  = '0;
    logic            sync     = 1'b0;
    logic            cfg_we   = 1'b0;
    logic [1:0]      cfg_ch   = 2'd0;
    logic [DW-1:0]   cfg_div  = '0;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  sq;

    tick_gen_multi #(
        .NUM_CH   (NCH),
        .DIV_W    (DW),
        .DIV_INIT (INIT)
    ) dut (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .en       (en),
        .mode_sq  (mode_sq),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .tick     (tick),
        .sq       (sq)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct packed {
        int             cyc;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: each channel remembers the cycle its current period started
    int     m_sh[NCH];
    int     m_act[NCH];
    longint m_start[NCH];
    longint cyc = 0;

    logic [NCH-1:0] nxt_en   = '0;
    logic [NCH-1:0] nxt_mode = '0;
    logic           nxt_sync = 1'b0;
    logic           nxt_we   = 1'b0;
    logic [1:0]     nxt_ch   = 2'd0;
    int             nxt_div  = 0;

    task automatic model_reset();
        logic [NCH*DW-1:0] iv;
        iv = INIT;
        for (int i = 0; i < NCH; i++) begin
            m_sh[i]    = int'(iv[i*DW +: DW]);
            m_act[i]   = m_sh[i];
            m_start[i] = cyc;
        end
    endtask

    // Drive pins for the coming edge and queue what that edge must produce
    task automatic drive_model();
        exp_t   e;
        longint el;
        longint ph;
        en      = nxt_en;
        mode_sq = nxt_mode;
        sync    = nxt_sync;
        cfg_we  = nxt_we;
        cfg_ch  = nxt_ch;
        cfg_div = nxt_div;
        cyc     = cyc + 1;
        e       = '0;
        e.cyc   = int'(cyc);
        for (int i = 0; i < NCH; i++) begin
            if (nxt_sync || !nxt_en[i] || m_act[i] == 0) begin
                m_start[i] = cyc;
                m_act[i]   = m_sh[i];
            end else begin
                el = cyc - m_start[i];
                ph = el % m_act[i];
                e.tick[i] = (el == m_act[i]);
                e.sq[i]   = nxt_mode[i] && (ph < (m_act[i] / 2));
                if (el == m_act[i]) begin
                    m_start[i] = cyc;
                    m_act[i]   = m_sh[i];
                end
            end
        end
        if (nxt_we && nxt_ch < NCH) m_sh[nxt_ch] = nxt_div;
        exp_q.push_back(e);
        nxt_we   = 1'b0;
        nxt_sync = 1'b0;
    endtask

    task automatic go(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_100M);
            drive_model();
        end
    endtask

    task automatic wr(input logic [1:0] c, input int d);
        nxt_we  = 1'b1;
        nxt_ch  = c;
        nxt_div = d;
        go(1);
    endtask

    task automatic do_reset();
        @(negedge clk_100M);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tick !== '0 || sq !== '0) begin
            errors++;
            $display("FAIL async_reset: tick=%b sq=%b required 000/000", tick, sq);
        end
        @(negedge clk_100M);
        rst_n = 1'b1;
        model_reset();
        drive_model();
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_100M);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (tick !== e.tick || sq !== e.sq) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: tick=%b sq=%b required tick=%b sq=%b",
                             e.cyc, tick, sq, e.tick, e.sq);
                end
            end
        end
    end

    initial begin
        #23;
        checks++;
        if (tick !== '0 || sq !== '0) begin
            errors++;
            $display("FAIL reset_state: tick=%b sq=%b required 000/000", tick, sq);
        end
        nxt_en   = 3'b111;
        nxt_mode = 3'b000;
        @(negedge clk_100M);
        rst_n = 1'b1;
        cyc   = 0;
        model_reset();
        drive_model();
        go(12);

        nxt_mode = 3'b001;
        go(8);
        wr(2'd0, 5);
        go(14);

        for (int k = 0; k < 6; k++) begin
            wr(2'd0, 4);
            go(4 + k);
            wr(2'd0, 2);
            go(9);
        end

        nxt_mode = 3'b111;
        for (int k = 0; k < 5; k++) begin
            wr(2'd0, 4);
            go(2);
            wr(2'd1, 4);
            go(5 + k);
            nxt_sync = 1'b1;
            go(1);
            go(10);
        end

        wr(2'd1, 0);
        go(7);
        wr(2'd1, 1);
        go(6);
        wr(2'd3, 7);
        go(8);

        wr(2'd0, 4);
        go(6);
        nxt_en = 3'b110;
        go(3);
        nxt_en = 3'b111;
        go(9);

        go(2);
        do_reset();
        go(14);

        for (int k = 0; k < 3000; k++) begin
            nxt_we   = ($urandom_range(0, 3) == 0);
            nxt_ch   = 2'($urandom_range(0, 3));
            nxt_div  = $urandom_range(0, 7);
            nxt_sync = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 30) == 0) nxt_en = 3'($urandom);
            if ($urandom_range(0, 20) == 0) nxt_mode = 3'($urandom);
            if ($urandom_range(0, 600) == 0) begin
                do_reset();
            end else begin
                go(1);
            end
        end

        @(posedge clk_100M);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: pending=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
